multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter SUBWORD_EN, default 1, meaning LB/LBU/LH/LHU/SB/SH are legal; when 0 they decode as illegal.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of mem_ready-low cycles tolerated per memory access (1..255).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- opcode  in  6  instruction-register opcode field
- mem_ready  in  1  memory access complete this cycle
- PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, RegWrite, ALUSrcA  out  1 each  datapath strobes and selects
- RegDst, MemtoReg, ALUSrcB, ALUOp, PCSource, MemDataSize  out  2 each  datapath selects
- MemDataSign  out  1  1 = signed access
- illegal  out  1  one-cycle pulse on an illegal opcode
- bus_error  out  1  one-cycle pulse on a memory timeout
- state  out  4  current FSM state, for debug

Function
REQ-005 SHALL use these opcodes: RFORMAT 0, ADDI 8, ANDI 12, LW 35, LB 32, LBU 36, LH 33, LHU 37, SW 43, SB 40, SH 41, BEQ 5, JAL 3.
REQ-006 SHALL implement 13 states: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JAL 9, IMMEXEC 10, IMMWB 11, TRAP 12.
REQ-007 SHALL, in FETCH, assert MemRead with IorD=0.
- Stay in FETCH while mem_ready=0.
- On mem_ready=1: pulse IRWrite and PCWrite, with ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; go to DECODE.
REQ-008 SHALL, in DECODE, set ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target), then go to:
- MEMADR for loads/stores
- EXEC for RFORMAT
- IMMEXEC for ADDI/ANDI
- BRANCH for BEQ
- JAL for JAL
- TRAP for anything else
REQ-009 SHALL, in MEMADR, set ALUSrcA=1, ALUSrcB=10, ALUOp=00; go to MEMRD for loads, MEMWR for stores.
REQ-010 SHALL, in MEMRD, assert MemRead with IorD=1; go to MEMWB on mem_ready=1, otherwise hold.
REQ-011 SHALL, in MEMWB, assert RegWrite with MemtoReg=01, RegDst=00; go to FETCH.
REQ-012 SHALL, in MEMWR, assert MemWrite with IorD=1; go to FETCH on mem_ready=1, otherwise hold.
REQ-013 SHALL, in EXEC, set ALUSrcA=1, ALUSrcB=00, ALUOp=10; then RWB asserts RegWrite with RegDst=01, MemtoReg=00; go to FETCH.
REQ-014 SHALL, in IMMEXEC, set ALUSrcA=1, ALUSrcB=10, ALUOp=00 for ADDI and 11 for ANDI; then IMMWB asserts RegWrite with RegDst=00, MemtoReg=00; go to FETCH.
REQ-015 SHALL, in BRANCH, assert PCWriteCond with ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01; go to FETCH.
REQ-016 SHALL, in JAL, assert RegWrite with RegDst=10, MemtoReg=10, and assert PCWrite with PCSource=10; go to FETCH.
REQ-017 SHALL, in TRAP, hold all strobes low for one cycle, then go to FETCH.
REQ-018 SHALL pulse illegal in the DECODE cycle whose transition targets TRAP.
REQ-019 SHALL drive MemDataSize (11 word, 10 half, 01 byte) and MemDataSign (1 for LW/LB/LH/SW/SB/SH) from opcode during MEMADR, MEMRD, MEMWB and MEMWR; both are 00/0 in all other states.
REQ-020 SHALL run a wait counter in FETCH, MEMRD and MEMWR, cleared on every state entry and incremented on each mem_ready=0 cycle.
REQ-021 SHALL, when the counter reaches MEM_TIMEOUT with mem_ready still 0, pulse bus_error, drop MemRead/MemWrite, and go to TRAP; mem_ready=1 in that same cycle wins over the timeout.
REQ-022 SHALL drive every strobe and select not listed for a state to 0/00.
REQ-023 SHALL decode outputs from state, opcode and mem_ready only (Moore outputs plus mem_ready-gated write enables).

Reset
REQ-024 SHALL, while reset=1, immediately force state=FETCH, wait counter=0, illegal=0, bus_error=0, and every write strobe (PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite) to 0.
REQ-025 SHALL, on reset asserted mid-access, abandon the access with no write strobe asserted; after release the first cycle is FETCH.

Structure
REQ-026 SHALL place opcode constants, state encodings and ALUOp/MemDataSize encodings in a shared package mips_ctrl_pkg.
REQ-027 SHALL use one sub-module, mem_wait_timer (counter plus timeout compare), instantiated once.

Verification
REQ-028 SHALL cover LW with mem_ready high in both FETCH and MEMRD -> states 0,1,2,3,4,0; RegWrite=1 with MemtoReg=01 only in state 4; MemDataSize=11 and MemDataSign=1 in states 2-4.
REQ-029 SHALL cover SB with mem_ready low for 3 cycles in MEMWR -> MemWrite held 4 cycles; state 5 held 4 cycles; MemDataSize=01.
REQ-030 SHALL cover opcode 6'd63 -> illegal pulses 1 cycle in DECODE; TRAP for 1 cycle; then FETCH; no write strobes asserted.
REQ-031 SHALL cover SUBWORD_EN=0 with LH -> illegal pulse and TRAP; LW still completes normally.
REQ-032 SHALL cover MEM_TIMEOUT=4 with mem_ready stuck low in FETCH -> bus_error pulse on the 4th wait cycle, then TRAP, then FETCH.
REQ-033 SHALL cover reset asserted during MEMRD -> state=0 and all write strobes 0 in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-style control unit:
// opcodes, FSM states, ALUOp and memory access sizes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RFORMAT = 6'd0;
  localparam logic [5:0] OP_ADDI    = 6'd8;
  localparam logic [5:0] OP_ANDI    = 6'd12;
  localparam logic [5:0] OP_LW      = 6'd35;
  localparam logic [5:0] OP_LB      = 6'd32;
  localparam logic [5:0] OP_LBU     = 6'd36;
  localparam logic [5:0] OP_LH      = 6'd33;
  localparam logic [5:0] OP_LHU     = 6'd37;
  localparam logic [5:0] OP_SW      = 6'd43;
  localparam logic [5:0] OP_SB      = 6'd40;
  localparam logic [5:0] OP_SH      = 6'd41;
  localparam logic [5:0] OP_BEQ     = 6'd5;
  localparam logic [5:0] OP_JAL     = 6'd3;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_RWB     = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JAL     = 4'd9;
  localparam logic [3:0] S_IMMEXEC = 4'd10;
  localparam logic [3:0] S_IMMWB   = 4'd11;
  localparam logic [3:0] S_TRAP    = 4'd12;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_AND  = 2'b11;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  function automatic logic is_load(
    input logic [5:0] op
  );
    return op == OP_LW || op == OP_LB ||
      op == OP_LBU || op == OP_LH ||
      op == OP_LHU;
  endfunction

  function automatic logic is_store(
    input logic [5:0] op
  );
    return op == OP_SW || op == OP_SB ||
      op == OP_SH;
  endfunction

  function automatic logic is_subword(
    input logic [5:0] op
  );
    return op == OP_LB || op == OP_LBU ||
      op == OP_LH || op == OP_LHU ||
      op == OP_SB || op == OP_SH;
  endfunction

  function automatic logic [1:0] mem_size(
    input logic [5:0] op
  );
    logic [1:0] sz;
    sz = SZ_NONE;
    unique case (1'b1)
      op == OP_LW, op == OP_SW: sz = SZ_WORD;
      op == OP_LH, op == OP_LHU,
      op == OP_SH: sz = SZ_HALF;
      op == OP_LB, op == OP_LBU,
      op == OP_SB: sz = SZ_BYTE;
      default: sz = SZ_NONE;
    endcase
    return sz;
  endfunction

  function automatic logic mem_signed(
    input logic [5:0] op
  );
    return op == OP_LW || op == OP_LB ||
      op == OP_LH || op == OP_SW ||
      op == OP_SB || op == OP_SH;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags the cycle that would
// reach the timeout limit.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic timeout
);

  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] cnt;

  // Fires on the wait cycle that makes the count hit the limit.
  assign timeout = waiting && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= 8'd0;
    else if (clear)
      cnt <= 8'd0;
    else if (waiting)
      cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM with subword memory access and a
// per-access memory wait timeout.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit SUBWORD_EN  = 1'b1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [1:0] MemDataSize,
  output logic       MemDataSign,
  output logic       illegal,
  output logic       bus_error,
  output logic [3:0] state
);

  logic [3:0] state_next;
  logic       legal_sub, is_ld, is_st;
  logic       waiting, timeout;
  logic       pcw, pcwc, irw, memw, regw, ill;

  assign legal_sub = SUBWORD_EN || !is_subword(opcode);
  assign is_ld = is_load(opcode) && legal_sub;
  assign is_st = is_store(opcode) && legal_sub;

  assign waiting = !mem_ready &&
    (state == S_FETCH || state == S_MEMRD ||
     state == S_MEMWR);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_next != state),
    .waiting(waiting),
    .timeout(timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_FETCH;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_FETCH:
        if (timeout) state_next = S_TRAP;
        else if (mem_ready) state_next = S_DECODE;
      S_DECODE:
        unique case (1'b1)
          is_ld, is_st:
            state_next = S_MEMADR;
          opcode == OP_RFORMAT:
            state_next = S_EXEC;
          opcode == OP_ADDI,
          opcode == OP_ANDI:
            state_next = S_IMMEXEC;
          opcode == OP_BEQ:
            state_next = S_BRANCH;
          opcode == OP_JAL:
            state_next = S_JAL;
          default:
            state_next = S_TRAP;
        endcase
      S_MEMADR:
        state_next = is_ld ? S_MEMRD : S_MEMWR;
      S_MEMRD:
        if (timeout) state_next = S_TRAP;
        else if (mem_ready) state_next = S_MEMWB;
      S_MEMWR:
        if (timeout) state_next = S_TRAP;
        else if (mem_ready) state_next = S_FETCH;
      S_EXEC:    state_next = S_RWB;
      S_IMMEXEC: state_next = S_IMMWB;
      default:   state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pcw = 1'b0; pcwc = 1'b0; irw = 1'b0;
    memw = 1'b0; regw = 1'b0; ill = 1'b0;
    IorD = 1'b0; MemRead = 1'b0;
    ALUSrcA = 1'b0; ALUSrcB = 2'b00;
    ALUOp = ALUOP_ADD; PCSource = 2'b00;
    RegDst = 2'b00; MemtoReg = 2'b00;
    MemDataSize = SZ_NONE; MemDataSign = 1'b0;
    unique case (state)
      S_FETCH: begin
        MemRead = !timeout;
        ALUSrcB = 2'b01;
        irw = mem_ready;
        pcw = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ill = (state_next == S_TRAP);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = !timeout;
        IorD = 1'b1;
      end
      S_MEMWB: begin
        regw = 1'b1;
        MemtoReg = 2'b01;
      end
      S_MEMWR: begin
        memw = !timeout;
        IorD = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp = ALUOP_FUNC;
      end
      S_RWB: begin
        regw = 1'b1;
        RegDst = 2'b01;
      end
      S_IMMEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp = (opcode == OP_ANDI) ?
          ALUOP_AND : ALUOP_ADD;
      end
      S_IMMWB: regw = 1'b1;
      S_BRANCH: begin
        pcwc = 1'b1;
        ALUSrcA = 1'b1;
        ALUOp = ALUOP_SUB;
        PCSource = 2'b01;
      end
      S_JAL: begin
        regw = 1'b1;
        RegDst = 2'b10;
        MemtoReg = 2'b10;
        pcw = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
    if (state inside {S_MEMADR, S_MEMRD,
                      S_MEMWB, S_MEMWR}) begin
      MemDataSize = mem_size(opcode);
      MemDataSign = mem_signed(opcode);
    end
  end

  // Reset must silence every write strobe without a clock edge.
  assign PCWrite     = pcw  && !reset;
  assign PCWriteCond = pcwc && !reset;
  assign IRWrite     = irw  && !reset;
  assign MemWrite    = memw && !reset;
  assign RegWrite    = regw && !reset;
  assign illegal     = ill  && !reset;
  assign bus_error   = timeout && !reset;

endmodule
